// File: rtl/arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM states and requester IDs.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_F = 2'd0,
    OWN_D = 2'd1,
    OWN_X = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_prio.sv
// Combinational winner pick: forced X first, then D > F > X.
module arb_prio
  import arb_pkg::*;
(
  input  logic   x_force,
  input  logic   x_req,
  input  logic   d_req,
  input  logic   f_req,
  output owner_e owner,
  output logic   valid
);

  always_comb begin
    owner = OWN_F;
    valid = 1'b1;
    if (x_force && x_req) begin
      owner = OWN_X;
    end else if (d_req) begin
      owner = OWN_D;
    end else if (f_req) begin
      owner = OWN_F;
    end else if (x_req) begin
      owner = OWN_X;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (F), data (D) and loader (X)
// requesters, one access at a time, with starvation protection for X.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 8,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_gnt,
  output logic          x_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned XW = $clog2(STARVE_MAX + 1);

  state_e        state_q,  state_d;
  owner_e        owner_q,  owner_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic          we_q,     we_d;
  logic [DW-1:0] wdata_q,  wdata_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [XW-1:0] x_wait_q, x_wait_d;
  logic [DW-1:0] rdata_q,  rdata_d;
  logic [2:0]    gnt_q,    gnt_d;
  logic [2:0]    done_q,   done_d;

  owner_e win_owner;
  logic   win_valid;
  logic   x_force;
  logic   grant;

  assign x_force = (x_wait_q == XW'(STARVE_MAX));
  assign grant   = (state_q == IDLE) && win_valid;

  arb_prio u_prio (
    .x_force (x_force),
    .x_req   (x_req),
    .d_req   (d_req),
    .f_req   (f_req),
    .owner   (win_owner),
    .valid   (win_valid)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    x_wait_d = x_wait_q;
    gnt_d    = '0;
    done_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          owner_d = win_owner;
          cnt_d   = CW'(MEM_LAT - 1);
          gnt_d   = 3'b001 << win_owner;
          state_d = BUSY;
          unique case (win_owner)
            OWN_D: begin
              addr_d  = d_addr;
              we_d    = d_we;
              wdata_d = d_wdata;
            end
            OWN_X: begin
              addr_d  = x_addr;
              we_d    = x_we;
              wdata_d = x_wdata;
            end
            default: begin
              addr_d  = f_addr;
              we_d    = 1'b0;
              wdata_d = '0;
            end
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        done_d  = 3'b001 << owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // X loses one grant each time D/F win while it waits; any idle x_req cycle forgives.
    if (!x_req) begin
      x_wait_d = '0;
    end else if (grant) begin
      if (win_owner == OWN_X) begin
        x_wait_d = '0;
      end else if (!x_force) begin
        x_wait_d = x_wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_F;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      x_wait_q <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      x_wait_q <= x_wait_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
    end
  end

  assign f_gnt     = gnt_q[0];
  assign d_gnt     = gnt_q[1];
  assign x_gnt     = gnt_q[2];
  assign f_done    = done_q[0];
  assign d_done    = done_q[1];
  assign x_done    = done_q[2];
  assign rdata     = rdata_q;
  assign mem_en    = (state_q == BUSY);
  assign mem_rw    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester processes, reference arbitration model, monitor.
module tb_mem_port_arbiter;

  localparam int unsigned LAT  = 3;
  localparam int unsigned SMAX = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       f_req = 1'b0, d_req = 1'b0, x_req = 1'b0;
  logic       d_we = 1'b0, x_we = 1'b0;
  logic [7:0] f_addr = '0, d_addr = '0, x_addr = '0, d_wdata = '0, x_wdata = '0;
  logic       f_gnt, f_done, d_gnt, d_done, x_gnt, x_done;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_en, mem_rw;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_done(x_done),
    .rdata(rdata), .mem_en(mem_en), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct { int who; bit we; logic [7:0] addr; logic [7:0] wdata; } req_t;
  typedef struct { int who; bit we; logic [7:0] addr; logic [7:0] wdata; logic [7:0] rdata; } exp_t;

  req_t fq[$], dq[$], xq[$];
  exp_t gnt_exp[$], done_exp[$];
  logic [7:0] tb_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] last_rd = '0;
  int compared = 0, mismatched = 0;
  bit mon_en = 1'b0, reinit = 1'b1;
  int cyc = 0;
  int unsigned en_run = 0;

  // Memory: data only valid on the last wait cycle, writes commit there too.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    en_run <= mem_en ? en_run + 1 : 0;
    if (reinit) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 8'(i) ^ 8'hA2;
    end else if (mem_en && mem_rw && en_run == LAT - 1) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_en && en_run == LAT - 1) ? tb_mem[mem_addr] : ~tb_mem[mem_addr];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] all_outs();
    return {f_gnt, f_done, d_gnt, d_done, x_gnt, x_done, mem_en, mem_rw,
            rdata, mem_addr, mem_wdata};
  endfunction

  // Reference: serve every pending access in priority order, tracking X's lost grants.
  task automatic model_round();
    int fi = 0, di = 0, xi = 0, xw = 0;
    req_t r;
    exp_t e;
    bit xp;
    while (fi < fq.size() || di < dq.size() || xi < xq.size()) begin
      xp = (xi < xq.size());
      if (xp && xw == SMAX) begin r = xq[xi]; xi++; end
      else if (di < dq.size()) begin r = dq[di]; di++; end
      else if (fi < fq.size()) begin r = fq[fi]; fi++; end
      else begin r = xq[xi]; xi++; end
      if (r.who == 2) xw = 0;
      else if (xp && xw < SMAX) xw++;
      e.who = r.who; e.we = r.we; e.addr = r.addr; e.wdata = r.wdata;
      if (r.we) begin
        ref_mem[r.addr] = r.wdata;
        e.rdata = last_rd;
      end else begin
        e.rdata = ref_mem[r.addr];
        last_rd = e.rdata;
      end
      gnt_exp.push_back(e);
      done_exp.push_back(e);
    end
  endtask

  task automatic drive(input int who, input bit v, input req_t r);
    case (who)
      0: begin f_req = v; f_addr = r.addr; end
      1: begin d_req = v; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata; end
      default: begin x_req = v; x_we = r.we; x_addr = r.addr; x_wdata = r.wdata; end
    endcase
  endtask

  function automatic logic gnt_of(input int who);
    return (who == 0) ? f_gnt : (who == 1) ? d_gnt : x_gnt;
  endfunction

  function automatic logic done_of(input int who);
    return (who == 0) ? f_done : (who == 1) ? d_done : x_done;
  endfunction

  function automatic int qsize(input int who);
    return (who == 0) ? fq.size() : (who == 1) ? dq.size() : xq.size();
  endfunction

  task automatic serve(input int who);
    req_t r, junk;
    int t;
    while (qsize(who) > 0) begin
      if (who == 0) r = fq.pop_front();
      else if (who == 1) r = dq.pop_front();
      else r = xq.pop_front();
      drive(who, 1'b1, r);
      t = 0;
      do begin @(negedge clk); t++; end while (!gnt_of(who) && t < 300);
      junk = '{who, 1'($urandom), 8'($urandom), 8'($urandom)};
      drive(who, 1'b0, junk);
      if (t >= 300) begin
        compared++; mismatched++;
        $display("FAIL gnt_timeout: requester %0d got no grant, required one", who);
        return;
      end
      t = 0;
      do begin @(negedge clk); t++; end while (!done_of(who) && t < 50);
      if (t >= 50) begin
        compared++; mismatched++;
        $display("FAIL done_timeout: requester %0d got no done, required one", who);
        return;
      end
    end
  endtask

  task automatic run_round();
    model_round();
    @(negedge clk);
    fork
      serve(0);
      serve(1);
      serve(2);
    join
    repeat (3) @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [7:0] held;
    logic [2:0] gnts, dones;
    int gcyc, ens;
    held = '0; gcyc = 0; ens = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!mem_en) check("rw_while_disabled", mem_rw, 0);
        gnts = {x_gnt, d_gnt, f_gnt};
        if (gnts != 3'b000) begin
          if (gnt_exp.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_gnt: got %b expected none", gnts);
          end else begin
            e = gnt_exp.pop_front();
            check("gnt_owner", gnts, 3'b001 << e.who);
            check("mem_en_at_gnt", mem_en, 1);
            check("mem_addr", mem_addr, e.addr);
            check("mem_rw", mem_rw, e.we);
            if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            gcyc = cyc;
            ens = 0;
          end
        end
        if (mem_en) begin
          ens++;
          check("rdata_hold", rdata, held);
        end
        dones = {x_done, d_done, f_done};
        if (dones != 3'b000) begin
          if (done_exp.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_done: got %b expected none", dones);
          end else begin
            e = done_exp.pop_front();
            check("done_owner", dones, 3'b001 << e.who);
            check("done_latency", cyc - gcyc, LAT + 1);
            check("mem_en_cycles", ens, LAT);
            check("rdata", rdata, e.rdata);
            held = e.rdata;
          end
        end
      end
    end
  end

  // Main stimulus
  initial begin
    logic seen;
    int t;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hA2;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    reset = 1'b1;
    reinit = 1'b0;
    @(negedge clk);

    // Reset during a D write abandons it silently.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'h5A;
    @(negedge clk);
    check("t1_d_gnt", d_gnt, 1);
    d_req = 1'b0;
    @(negedge clk);
    check("t1_busy", {mem_en, mem_rw, mem_addr}, {2'b11, 8'h10});
    reset = 1'b0;
    #1;
    check("t1_outputs_in_reset", all_outs(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= d_done | f_done | x_done | d_gnt | mem_en;
    end
    check("t1_no_done_after_reset", seen, 0);
    mon_en = 1'b1;

    // F read of 0x05 (memory holds 0xA7).
    fq.push_back('{0, 1'b0, 8'h05, 8'h00});
    run_round();

    // Simultaneous F and D: D write wins first.
    fq.push_back('{0, 1'b0, 8'h21, 8'h00});
    dq.push_back('{1, 1'b1, 8'h20, 8'h3C});
    run_round();

    // Waiting X forced in after exactly SMAX D/F grants.
    for (int i = 0; i < 4; i++) dq.push_back('{1, 1'($urandom), 8'($urandom), 8'($urandom)});
    for (int i = 0; i < 2; i++) fq.push_back('{0, 1'b0, 8'($urandom), 8'h00});
    xq.push_back('{2, 1'b0, 8'h20, 8'h00});
    run_round();

    // D pulse while F is busy must be ignored.
    fq.push_back('{0, 1'b0, 8'h20, 8'h00});
    model_round();
    @(negedge clk);
    fork
      serve(0);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!f_gnt && t < 50);
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h44;
        @(negedge clk);
        d_req = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen |= d_gnt; end
        check("t5_no_d_gnt", seen, 0);
      end
    join
    repeat (3) @(negedge clk);

    // Random mixes.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        fq.push_back('{0, 1'b0, 8'($urandom_range(0, 15)), 8'h00});
      for (int i = 0; i < int'($urandom_range(0, 4)); i++)
        dq.push_back('{1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom)});
      for (int i = 0; i < int'($urandom_range(0, 2)); i++)
        xq.push_back('{2, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom)});
      run_round();
    end

    repeat (5) @(negedge clk);
    check("gnt_queue_drained", gnt_exp.size(), 0);
    check("done_queue_drained", done_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end

endmodule
